// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back front end.
// Entry and request layouts are common to the arbiter, its FIFO and any checker.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  live;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer for slow-path write-backs with per-entry live bits.
// A kill clears live bits of matching entries; killed entries still pop in order.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic [PW:0]           count,
  output logic                  head_live,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic [31:0]           live_rd_mask
);

  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]      live;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;

  // Kill first, then pop-clear, then push: a same-cycle push to the killed
  // rd is younger than the killing write and must stay live.
  always_ff @(posedge clk) begin
    if (rst) begin
      live  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && live[i] && (rd_q[i] == kill_rd)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rptr] <= 1'b0;
        rptr       <= rptr + 1'b1;
      end
      if (push) begin
        live[wptr]   <= 1'b1;
        rd_q[wptr]   <= push_rd;
        data_q[wptr] <= push_data;
        wptr         <= wptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_live = live[rptr];
  assign head_rd   = rd_q[rptr];
  assign head_data = data_q[rptr];

  always_comb begin
    live_rd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i]) live_rd_mask[rd_q[i]] = 1'b1;
    end
    live_rd_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges the ALU path (absolute priority) and buffered slow path onto one
// register-file write port, and publishes the pending-destination mask.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       write_data,
  output logic [31:0]           pending_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  // Handshake: slow path transfers on b_valid && b_ready. b_ready depends only
  // on reset and the registered FIFO count, never on a same-cycle pop.
  logic                  a_req;
  logic                  b_push;
  logic                  fifo_pop;
  logic [PW:0]           count;
  logic                  head_live;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [31:0]           live_rd_mask;
  logic [31:0]           out_mask;

  assign a_req    = a_valid && (a_rd != '0);
  assign b_ready  = !rst && (count < FULL_CNT);
  assign b_push   = b_valid && b_ready && (b_rd != '0);
  assign fifo_pop = !a_req && (count != '0);

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (b_push),
    .push_rd      (b_rd),
    .push_data    (b_data),
    .pop          (fifo_pop),
    .kill_en      (a_req),
    .kill_rd      (a_rd),
    .count        (count),
    .head_live    (head_live),
    .head_rd      (head_rd),
    .head_data    (head_data),
    .live_rd_mask (live_rd_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else if (a_req) begin
      reg_write  <= 1'b1;
      rd         <= a_rd;
      write_data <= a_data;
    end else if (fifo_pop) begin
      reg_write  <= head_live;
      rd         <= head_rd;
      write_data <= head_data;
    end else begin
      reg_write  <= 1'b0;
    end
  end

  always_comb begin
    out_mask = '0;
    if (reg_write) out_mask[rd] = 1'b1;
    pending_mask    = live_rd_mask | out_mask;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-level model
// of the write-back rules, with a per-cycle output scoreboard.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = 1 + 5 + 32 + 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending_mask;

  wb_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_rd         (a_rd),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_rd         (b_rd),
    .b_data       (b_data),
    .reg_write    (reg_write),
    .rd           (rd),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: queued writes in age order plus the visible output.
  wb_entry_t   mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cycle(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    logic        rdy;
    logic [31:0] mask;
    @(negedge clk);
    rst = r; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #1;
    rdy = !r && (mq.size() < DEPTH);
    check("b_ready", EW'(b_ready), EW'(rdy));
    if (r) begin
      mq.delete();
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      if (av && ard != 0) begin
        foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
        m_we = 1'b1; m_rd = ard; m_data = ad;
      end else if (mq.size() > 0) begin
        wb_entry_t e;
        e = mq.pop_front();
        m_we = e.live; m_rd = e.rd; m_data = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (bv && rdy && brd != 0) mq.push_back('{live: 1'b1, rd: brd, data: bd});
    end
    mask = '0;
    foreach (mq[i]) if (mq[i].live) mask[mq[i].rd] = 1'b1;
    if (m_we) mask[m_rd] = 1'b1;
    mask[0] = 1'b0;
    exp_q.push_back({m_we, m_rd, m_data, mask});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every registered output update is compared against the model.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check("out", {reg_write, rd, write_data, pending_mask}, e);
    end
  end

  initial begin
    // Reset then idle.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd1);
    idle(2);
    // A only.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    idle(2);
    // Fill under constant A, then a refused B, then drain x1..x4.
    for (int i = 1; i <= 4; i++)
      cycle(1'b0, 1'b1, 5'd20, $urandom, 1'b1, 5'(i), 32'h100 + 32'(i));
    cycle(1'b0, 1'b1, 5'd21, 32'h55, 1'b1, 5'd6, 32'h66);
    idle(6);
    // WAW kill.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    cycle(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
    idle(3);
    // Same-cycle A/B to the same rd: B is younger.
    cycle(1'b0, 1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
    idle(3);
    // Reset with three entries queued.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 5'd10, 32'h10 + 32'(i), 1'b1, 5'd11 + 5'(i), 32'h20 + 32'(i));
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(3);
    // b_rd = 0 is a handshake only.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    idle(2);
    // Hold count at 3 with push+pop across pointer wrap.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 5'd30, 32'(i), 1'b1, 5'd12 + 5'(i), 32'h300 + 32'(i));
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16 + 5'(i), 32'h400 + 32'(i));
    idle(5);
    // Randomized traffic with a narrow rd range to provoke kills.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 12)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 12)), $urandom);
    end
    idle(6);
    @(negedge clk);
    check("drain", EW'(exp_q.size()), EW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
